// File: rtl/render_arbiter_pkg.sv
// render_pkg: shared state encoding, colour constants and default screen size
// for the render arbiter and its optional screen sweep.
// Optional feature macro: RENDER_ARB_CLEAR_EN adds the CLEAR state.
package render_pkg;

  localparam int unsigned DEF_X_SCREEN_PIXELS = 320;
  localparam int unsigned DEF_Y_SCREEN_PIXELS = 240;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  // Arbiter sequencing states; CLEAR only exists in the screen-clear build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
`ifdef RENDER_ARB_CLEAR_EN
    ST_FINISH = 3'd3,
    ST_CLEAR  = 3'd4
`else
    ST_FINISH = 3'd3
`endif
  } state_t;

endpackage

// File: rtl/render_arbiter_screen_sweep.sv
// screen_sweep: row-major x/y pixel counter used to blank the screen.
// Exists only when RENDER_ARB_CLEAR_EN is defined.
// Ports:
//   iClock   clock (posedge)
//   iReset   synchronous active-high reset, counters to (0,0)
//   iRun     advance one pixel per cycle while high
//   oX, oY   current sweep position (registered counters)
//   oDone_c  combinational: current position is the last pixel and iRun is high
`ifdef RENDER_ARB_CLEAR_EN
module screen_sweep #(
  parameter int unsigned X_PIXELS = 320,
  parameter int unsigned Y_PIXELS = 240,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic          iRun,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic          oDone_c
);

  localparam logic [XW-1:0] X_LAST = XW'(X_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_PIXELS - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_wrap;

  assign w_x_wrap = (r_x == X_LAST);

  // x is the inner index, y the outer; both wrap so a later run restarts at (0,0).
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (iRun) begin
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign oX      = r_x;
  assign oY      = r_y;
  assign oDone_c = iRun && w_x_wrap && (r_y == Y_LAST);

endmodule
`endif

// File: rtl/render_arbiter.sv
// render_arbiter: serves pixel requesters in ascending index order once per
// frame and muxes the granted requester onto a registered VGA pixel bus.
// Optional feature macro: RENDER_ARB_CLEAR_EN (post-reset full-screen clear).
// Ports:
//   iClock, iReset       clock, synchronous active-high reset
//   iFrameTick           frame start pulse (dropped with oOverrun when busy)
//   iReqEn               per-requester enable
//   iReqX/iReqY/iReqColour/iReqPlot  packed requester pixel buses
//   iReqDone             per-requester drawing-complete level
//   oReqStart, oGrant    start pulse and one-hot grant
//   oX/oY/oColour/oPlot  registered VGA pixel bus
//   oFrameDone, oBusy, oOverrun  frame status
module render_arbiter
  import render_pkg::*;
#(
  parameter int unsigned N_REQ           = 3,
  parameter int unsigned X_SCREEN_PIXELS = DEF_X_SCREEN_PIXELS,
  parameter int unsigned Y_SCREEN_PIXELS = DEF_Y_SCREEN_PIXELS,
  localparam int unsigned XW = $clog2(X_SCREEN_PIXELS) + 1,
  localparam int unsigned YW = $clog2(Y_SCREEN_PIXELS) + 1
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iFrameTick,
  input  logic [N_REQ-1:0]    iReqEn,
  input  logic [N_REQ*XW-1:0] iReqX,
  input  logic [N_REQ*YW-1:0] iReqY,
  input  logic [N_REQ*3-1:0]  iReqColour,
  input  logic [N_REQ-1:0]    iReqPlot,
  input  logic [N_REQ-1:0]    iReqDone,
  output logic [N_REQ-1:0]    oReqStart,
  output logic [N_REQ-1:0]    oGrant,
  output logic [XW-1:0]       oX,
  output logic [YW-1:0]       oY,
  output logic [2:0]          oColour,
  output logic                oPlot,
  output logic                oFrameDone,
  output logic                oBusy,
  output logic                oOverrun
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef RENDER_ARB_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam logic   RESET_BUSY  = 1'b1;
`else
  localparam state_t RESET_STATE = ST_IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic               r_wait_first;
  logic [N_REQ-1:0]   r_start;
  logic [N_REQ-1:0]   r_grant;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [2:0]         r_colour;
  logic               r_plot;
  logic               r_frame_done;
  logic               r_busy;
  logic               r_overrun;

  logic               w_first_found;
  logic [IW-1:0]      w_first_idx;
  logic               w_next_found;
  logic [IW-1:0]      w_next_idx;
  logic [N_REQ-1:0]   w_first_oh;
  logic [N_REQ-1:0]   w_next_oh;
  logic [XW-1:0]      w_sel_x;
  logic [YW-1:0]      w_sel_y;
  logic [2:0]         w_sel_colour;

  // Lowest enabled requester overall, and lowest enabled above the current one.
  // Enables are read live, so a change mid-frame only affects the next selection.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (iReqEn[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = IW'(i);
        if (i > int'(r_idx)) begin
          w_next_found = 1'b1;
          w_next_idx   = IW'(i);
        end
      end
    end
  end

  assign w_first_oh   = N_REQ'(1) << w_first_idx;
  assign w_next_oh    = N_REQ'(1) << w_next_idx;
  assign w_sel_x      = iReqX[r_idx*XW +: XW];
  assign w_sel_y      = iReqY[r_idx*YW +: YW];
  assign w_sel_colour = iReqColour[r_idx*3 +: 3];

`ifdef RENDER_ARB_CLEAR_EN
  logic          w_sweep_run;
  logic [XW-1:0] w_sweep_x;
  logic [YW-1:0] w_sweep_y;
  logic          w_sweep_done;

  assign w_sweep_run = (r_state == ST_CLEAR);

  screen_sweep #(
    .X_PIXELS (X_SCREEN_PIXELS),
    .Y_PIXELS (Y_SCREEN_PIXELS),
    .XW       (XW),
    .YW       (YW)
  ) u_sweep (
    .iClock  (iClock),
    .iReset  (iReset),
    .iRun    (w_sweep_run),
    .oX      (w_sweep_x),
    .oY      (w_sweep_y),
    .oDone_c (w_sweep_done)
  );
`endif

  // Sequencing FSM and registered pixel mux.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state      <= RESET_STATE;
      r_idx        <= '0;
      r_wait_first <= 1'b0;
      r_start      <= '0;
      r_grant      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= RESET_BUSY;
      r_overrun    <= 1'b0;
    end else begin
      r_start      <= '0;
      r_frame_done <= 1'b0;
      // Ticks outside IDLE are flagged and discarded, never queued.
      r_overrun    <= iFrameTick && (r_state != ST_IDLE);

      // Bus follows the granted slice one cycle late; coordinates hold otherwise.
      if (|r_grant) begin
        r_x      <= w_sel_x;
        r_y      <= w_sel_y;
        r_colour <= w_sel_colour;
        r_plot   <= iReqPlot[r_idx];
      end else begin
        r_plot   <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (iFrameTick) begin
            r_busy <= 1'b1;
            if (w_first_found) begin
              r_state <= ST_START;
              r_idx   <= w_first_idx;
              r_start <= w_first_oh;
              r_grant <= w_first_oh;
            end else begin
              r_state <= ST_FINISH;
            end
          end
        end
        ST_START: begin
          r_state      <= ST_WAIT;
          r_wait_first <= 1'b1;
        end
        ST_WAIT: begin
          r_wait_first <= 1'b0;
          // Done flags are stale in the first WAIT cycle after a start.
          if (!r_wait_first && iReqDone[r_idx]) begin
            if (w_next_found) begin
              r_state <= ST_START;
              r_idx   <= w_next_idx;
              r_start <= w_next_oh;
              r_grant <= w_next_oh;
            end else begin
              r_state <= ST_FINISH;
              r_grant <= '0;
            end
          end
        end
        ST_FINISH: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b1;
        end
`ifdef RENDER_ARB_CLEAR_EN
        ST_CLEAR: begin
          r_x      <= w_sweep_x;
          r_y      <= w_sweep_y;
          r_colour <= COL_BLACK;
          r_plot   <= 1'b1;
          if (w_sweep_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oReqStart  = r_start;
  assign oGrant     = r_grant;
  assign oX         = r_x;
  assign oY         = r_y;
  assign oColour    = r_colour;
  assign oPlot      = r_plot;
  assign oFrameDone = r_frame_done;
  assign oBusy      = r_busy;
  assign oOverrun   = r_overrun;

endmodule

// File: tb/tb_render_arbiter.sv
// Directed testbench for render_arbiter (default 3 requesters, 320x240).
// Define RENDER_ARB_CLEAR_EN to also exercise the screen-clear sweep.
`timescale 1ns/1ps
module tb_render_arbiter;

  localparam int N  = 3;
  localparam int XW = 10;
  localparam int YW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick;
  logic [N-1:0]    en;
  logic [N*XW-1:0] rx;
  logic [N*YW-1:0] ry;
  logic [N*3-1:0]  rc;
  logic [N-1:0]    plot;
  logic [N-1:0]    done;
  logic [N-1:0]    oReqStart;
  logic [N-1:0]    oGrant;
  logic [XW-1:0]   oX;
  logic [YW-1:0]   oY;
  logic [2:0]      oColour;
  logic            oPlot;
  logic            oFrameDone;
  logic            oBusy;
  logic            oOverrun;

  int errors = 0;
  int checks = 0;

  // Frame recorder state filled by run_frame.
  int         rq_cnt[N];
  int         start_cyc[N];
  int         start_cnt[N];
  int         done_cyc[N];
  int         seq[$];
  logic [2:0] gseq[$];
  int         fd_cyc, fd_cnt, ov_cyc, ov_cnt, bad_plot, leak;
  bit         stopped;

  always #5 clk = ~clk;

  render_arbiter dut (
    .iClock     (clk),
    .iReset     (rst),
    .iFrameTick (tick),
    .iReqEn     (en),
    .iReqX      (rx),
    .iReqY      (ry),
    .iReqColour (rc),
    .iReqPlot   (plot),
    .iReqDone   (done),
    .oReqStart  (oReqStart),
    .oGrant     (oGrant),
    .oX         (oX),
    .oY         (oY),
    .oColour    (oColour),
    .oPlot      (oPlot),
    .oFrameDone (oFrameDone),
    .oBusy      (oBusy),
    .oOverrun   (oOverrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input logic [2:0] c);
    rx[i*XW +: XW] = XW'(x);
    ry[i*YW +: YW] = YW'(y);
    rc[i*3 +: 3]   = c;
  endtask

  task automatic default_reqs();
    for (int i = 0; i < N; i++) set_req(i, 20 + i, 30 + i, 3'(i + 1));
  endtask

  // Runs one frame with a requester model: each requester plots while busy and
  // raises done 45 cycles after it sees its start pulse. Cycle 0 carries the tick.
  task automatic run_frame(input logic [2:0] e, input int tick_at, input bit inject2,
                           input int stop_after_g1);
    logic [2:0] last_g;
    int         g1_cycles;
    last_g    = '0;
    g1_cycles = 0;
    for (int i = 0; i < N; i++) begin
      rq_cnt[i] = 0; start_cyc[i] = -1; start_cnt[i] = 0; done_cyc[i] = -1;
    end
    seq.delete(); gseq.delete();
    fd_cyc = -1; fd_cnt = 0; ov_cyc = -1; ov_cnt = 0; bad_plot = 0; leak = 0;
    stopped = 1'b0;
    done = '0; plot = '0; default_reqs();
    en   = e;
    tick = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      tick = (c == tick_at);
      for (int i = 0; i < N; i++) begin
        if (oReqStart[i]) begin
          start_cnt[i]++; start_cyc[i] = c; seq.push_back(i);
          rq_cnt[i] = 45; done[i] = 1'b0;
        end else if (rq_cnt[i] > 0) begin
          rq_cnt[i]--;
          if (rq_cnt[i] == 0) begin done[i] = 1'b1; done_cyc[i] = c; end
        end
        plot[i] = (rq_cnt[i] > 0);
      end
      if (inject2 && oGrant === 3'b001) begin
        set_req(2, 7, 9, 3'b101);
        plot[2] = 1'b1;
      end else begin
        set_req(2, 22, 32, 3'd3);
      end
      if (oGrant !== 3'b000 && oGrant !== last_g) gseq.push_back(oGrant);
      last_g = oGrant;
      if (oPlot === 1'b1 && oGrant === 3'b000) bad_plot++;
      if (oX === 10'd7 && oY === 9'd9) leak++;
      if (oFrameDone === 1'b1) begin fd_cnt++; fd_cyc = c; end
      if (oOverrun === 1'b1) begin ov_cnt++; ov_cyc = c; end
      if (oGrant === 3'b010) g1_cycles++;
      if (stop_after_g1 > 0 && g1_cycles == stop_after_g1) begin stopped = 1'b1; break; end
      if (fd_cnt > 0 && c >= fd_cyc + 3) break;
    end
    tick = 1'b0; done = '0; plot = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; en = '0; plot = '0; done = '0; default_reqs();
    step(); step(); step();
    if ({oReqStart, oGrant, oPlot, oFrameDone, oOverrun} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got start=%b grant=%b plot=%b fd=%b ov=%b, expected all 0",
                         oReqStart, oGrant, oPlot, oFrameDone, oOverrun);
    end
    checks++;
    if ({oX, oY, oColour} !== '0) begin
      errors++; $display("FAIL reset_bus: got x=%0d y=%0d c=%0d, expected 0", oX, oY, oColour);
    end
    checks++;
`ifdef RENDER_ARB_CLEAR_EN
    if (oBusy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", oBusy); end
`else
    if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
`endif
    checks++;
    rst = 1'b0;
  endtask

`ifdef RENDER_ARB_CLEAR_EN
  task automatic test_clear();
    int n, order_err, ex, ey, lx, ly;
    bit ended;
    n = 0; order_err = 0; ex = 0; ey = 0; lx = -1; ly = -1; ended = 1'b0;
    tick = 1'b1;
    for (int c = 0; c < 77000; c++) begin
      step();
      if (oPlot === 1'b1) begin
        if (oX !== XW'(ex) || oY !== YW'(ey) || oColour !== 3'b000) order_err++;
        lx = int'(oX); ly = int'(oY); n++;
        ex++;
        if (ex == 320) begin ex = 0; ey++; end
      end else if (n > 0) begin
        ended = 1'b1;
        break;
      end
    end
    tick = 1'b0;
    if (n !== 76800) begin errors++; $display("FAIL clear_count: got %0d expected 76800", n); end
    checks++;
    if (order_err !== 0) begin errors++; $display("FAIL clear_order: got %0d bad pixels expected 0", order_err); end
    checks++;
    if (lx !== 319 || ly !== 239) begin
      errors++; $display("FAIL clear_last: got (%0d,%0d) expected (319,239)", lx, ly);
    end
    checks++;
    if (!ended || oBusy !== 1'b0) begin
      errors++; $display("FAIL clear_busy_end: got ended=%0d busy=%b expected 1/0", ended, oBusy);
    end
    checks++;
    step(); step();
    if (oOverrun !== 1'b0) begin errors++; $display("FAIL clear_ov_idle: got %b expected 0", oOverrun); end
    checks++;
  endtask
`endif

  task automatic test_normal_frame();
    run_frame(3'b111, -1, 1'b0, 0);
    if (seq.size() !== 3 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 2) begin
      errors++; $display("FAIL normal_order: got %0d starts, expected 0,1,2", seq.size());
    end
    checks++;
    if (start_cyc[0] !== 1 || start_cyc[1] !== 47 || start_cyc[2] !== 93) begin
      errors++; $display("FAIL normal_start_cyc: got %0d/%0d/%0d expected 1/47/93",
                         start_cyc[0], start_cyc[1], start_cyc[2]);
    end
    checks++;
    if (fd_cnt !== 1 || fd_cyc !== done_cyc[2] + 2 || fd_cyc !== 140) begin
      errors++; $display("FAIL normal_frame_done: got cnt=%0d cyc=%0d expected 1 at 140", fd_cnt, fd_cyc);
    end
    checks++;
    if (bad_plot !== 0) begin errors++; $display("FAIL normal_plot_idle: got %0d expected 0", bad_plot); end
    checks++;
    if (oBusy !== 1'b0 || oGrant !== 3'b000) begin
      errors++; $display("FAIL normal_idle_after: got busy=%b grant=%b expected 0/000", oBusy, oGrant);
    end
    checks++;
  endtask

  task automatic test_skip();
    run_frame(3'b101, -1, 1'b0, 0);
    if (start_cnt[1] !== 0) begin errors++; $display("FAIL skip_start1: got %0d expected 0", start_cnt[1]); end
    checks++;
    if (gseq.size() !== 2 || gseq[0] !== 3'b001 || gseq[1] !== 3'b100) begin
      errors++; $display("FAIL skip_grant_seq: got %0d grants, expected 001 then 100", gseq.size());
    end
    checks++;
    if (start_cyc[2] !== 47 || fd_cyc !== 94) begin
      errors++; $display("FAIL skip_timing: got start2=%0d fd=%0d expected 47/94", start_cyc[2], fd_cyc);
    end
    checks++;
  endtask

  task automatic test_overrun_isolation();
    run_frame(3'b111, 10, 1'b1, 0);
    if (ov_cnt !== 1 || ov_cyc !== 11) begin
      errors++; $display("FAIL overrun_pulse: got cnt=%0d cyc=%0d expected 1 at 11", ov_cnt, ov_cyc);
    end
    checks++;
    if (start_cnt[0] !== 1 || start_cnt[1] !== 1 || start_cnt[2] !== 1 || fd_cnt !== 1 || fd_cyc !== 140) begin
      errors++; $display("FAIL overrun_no_restart: got starts %0d/%0d/%0d fd=%0d@%0d expected 1/1/1 1@140",
                         start_cnt[0], start_cnt[1], start_cnt[2], fd_cnt, fd_cyc);
    end
    checks++;
    if (leak !== 0) begin errors++; $display("FAIL mux_isolation: got %0d leaked cycles expected 0", leak); end
    checks++;
  endtask

  task automatic test_stale_done_latency();
    en = 3'b001; done = 3'b001; plot = '0; default_reqs();
    tick = 1'b1;
    step(); tick = 1'b0;                                       // START
    if (oReqStart !== 3'b001 || oGrant !== 3'b001) begin
      errors++; $display("FAIL stale_start: got start=%b grant=%b expected 001/001", oReqStart, oGrant);
    end
    checks++;
    set_req(0, 100, 50, 3'b111); plot = 3'b001;
    step();                                                    // WAIT 1: done ignored
    if (oGrant !== 3'b001) begin errors++; $display("FAIL stale_wait1: got %b expected 001", oGrant); end
    checks++;
    if (oX !== 10'd100 || oY !== 9'd50 || oColour !== 3'b111 || oPlot !== 1'b1) begin
      errors++; $display("FAIL latency_pixel: got (%0d,%0d,%0d,%b) expected (100,50,7,1)", oX, oY, oColour, oPlot);
    end
    checks++;
    set_req(0, 101, 51, 3'b111);
    step();                                                    // WAIT 2: done sampled
    if (oGrant !== 3'b001 || oX !== 10'd101) begin
      errors++; $display("FAIL stale_wait2: got grant=%b x=%0d expected 001/101", oGrant, oX);
    end
    checks++;
    set_req(0, 150, 60, 3'b110);
    step();                                                    // FINISH
    if (oGrant !== 3'b000 || oX !== 10'd150) begin
      errors++; $display("FAIL finish_grant: got grant=%b x=%0d expected 000/150", oGrant, oX);
    end
    checks++;
    set_req(0, 222, 99, 3'b010);
    step();
    if (oPlot !== 1'b0 || oX !== 10'd150 || oY !== 9'd60 || oFrameDone !== 1'b1) begin
      errors++; $display("FAIL hold_when_idle: got plot=%b x=%0d y=%0d fd=%b expected 0/150/60/1",
                         oPlot, oX, oY, oFrameDone);
    end
    checks++;
    done = '0; plot = '0; default_reqs();
    step(); step();
  endtask

  task automatic test_no_enable();
    run_frame(3'b000, -1, 1'b0, 0);
    if (seq.size() !== 0 || fd_cnt !== 1 || fd_cyc !== 2) begin
      errors++; $display("FAIL no_enable: got starts=%0d fd=%0d@%0d expected 0, 1@2", seq.size(), fd_cnt, fd_cyc);
    end
    checks++;
  endtask

  task automatic test_reset_mid_wait();
    int stray;
    stray = 0;
    run_frame(3'b111, -1, 1'b0, 3);
    if (!stopped || oX !== 10'd21) begin
      errors++; $display("FAIL midreset_setup: got stopped=%0d x=%0d expected 1/21", stopped, oX);
    end
    checks++;
    rst = 1'b1;
    step();
    if ({oReqStart, oGrant, oPlot, oX, oY, oColour, oFrameDone, oOverrun} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got grant=%b plot=%b x=%0d y=%0d c=%0d expected 0",
                         oGrant, oPlot, oX, oY, oColour);
    end
    checks++;
    rst = 1'b0;
`ifndef RENDER_ARB_CLEAR_EN
    for (int c = 0; c < 5; c++) begin
      step();
      if (oReqStart !== 3'b000 || oGrant !== 3'b000) stray++;
    end
    if (stray !== 0 || oBusy !== 1'b0) begin
      errors++; $display("FAIL midreset_no_restart: got stray=%0d busy=%b expected 0/0", stray, oBusy);
    end
    checks++;
    run_frame(3'b111, -1, 1'b0, 0);
    if (seq.size() !== 3 || seq[0] !== 0 || start_cyc[0] !== 1) begin
      errors++; $display("FAIL midreset_next_frame: got %0d starts first@%0d expected req0 @1",
                         seq.size(), start_cyc[0]);
    end
    checks++;
`endif
  endtask

  initial begin
    test_reset();
`ifdef RENDER_ARB_CLEAR_EN
    test_clear();
`else
    step();
`endif
    test_normal_frame();
    test_skip();
    test_overrun_isolation();
    test_stale_done_latency();
    test_no_enable();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/render_arbiter.md
RENDER_ARBITER -- requirements
Module: render_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of pixel requesters (0 = left paddle, 1 = right paddle, 2 = ball).
REQ-002 Parameter X_SCREEN_PIXELS, default 320: screen width. XW = $clog2(X_SCREEN_PIXELS)+1.
REQ-003 Parameter Y_SCREEN_PIXELS, default 240: screen height. YW = $clog2(Y_SCREEN_PIXELS)+1.
REQ-004 The block SHALL have one clock and one synchronous, active-high reset:
- iClock  in  1  sole clock; all logic on posedge.
- iReset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have the following ports:
- iFrameTick  in  1  one-cycle frame pulse from the rate divider.
- iReqEn  in  N_REQ  per-requester enable; a disabled requester is skipped.
- iReqX  in  N_REQ*XW  packed requester X; slice i = requester i.
- iReqY  in  N_REQ*YW  packed requester Y.
- iReqColour  in  N_REQ*3  packed requester colour.
- iReqPlot  in  N_REQ  requester pixel valid.
- iReqDone  in  N_REQ  requester level "drawing complete".
- oReqStart  out  N_REQ  one-cycle start pulse to a requester.
- oGrant  out  N_REQ  one-hot grant; all zeros when no requester is granted.
- oX / oY / oColour  out  XW / YW / 3  VGA pixel bus.
- oPlot  out  1  VGA write enable.
- oFrameDone  out  1  one-cycle pulse when all requesters have finished for the frame.
- oBusy  out  1  high in any state except IDLE.
- oOverrun  out  1  one-cycle pulse when an iFrameTick is dropped.

Function
REQ-006 The state machine SHALL have the states CLEAR, IDLE, START, WAIT, FINISH.
REQ-007 IDLE with iFrameTick=1: go to START with idx = the lowest enabled requester. If no requester is enabled, go directly to FINISH.
REQ-008 START (1 cycle): oReqStart[idx]=1 and oGrant[idx]=1, then go to WAIT.
REQ-009 WAIT: oGrant[idx] SHALL be held. iReqDone[idx] SHALL be ignored in the first WAIT cycle, because requester done flags are stale for one cycle after start. Done is sampled from the second WAIT cycle on.
REQ-010 On a sampled iReqDone[idx]=1: go to START for the next-higher enabled index. If none remains, go to FINISH. Requesters SHALL be served in ascending index order, once per frame.
REQ-011 FINISH (1 cycle): oFrameDone=1, oGrant=0, then go to IDLE.
REQ-012 The pixel bus SHALL be registered with one cycle of latency: oX/oY/oColour/oPlot at cycle t+1 equal slice idx of the inputs at cycle t while oGrant[idx]=1.
REQ-013 When no requester is granted, oPlot SHALL be 0 and oX/oY/oColour SHALL hold their last values.
REQ-014 The iReqPlot input of any non-granted requester SHALL have no effect on the outputs.
REQ-015 An iFrameTick in any state other than IDLE SHALL be dropped and SHALL produce oOverrun=1 in the next cycle. It SHALL NOT be queued.
REQ-016 An iReqEn change during a frame SHALL take effect only when the next index is selected. The current grant SHALL NOT be revoked.
REQ-017 oBusy SHALL be 1 in CLEAR, START, WAIT and FINISH.

Reset
REQ-018 iReset=1 at any posedge, including mid-frame, SHALL force: oReqStart=0, oGrant=0, oPlot=0, oX=0, oY=0, oColour=0, oFrameDone=0, oOverrun=0, idx=0.
REQ-019 After reset the state SHALL be CLEAR if RENDER_ARB_CLEAR_EN is defined, and IDLE otherwise.
REQ-020 A requester that was granted when reset hit receives no further start pulse until the next frame.

Configuration
REQ-021 With macro RENDER_ARB_CLEAR_EN defined, CLEAR SHALL sweep the whole screen:
- order: row-major, x 0..X_SCREEN_PIXELS-1 inner, y 0..Y_SCREEN_PIXELS-1 outer;
- output: oColour=000, oPlot=1, one pixel per cycle, outputs registered;
- duration: 76800 cycles at default parameters, then IDLE;
- iFrameTick during CLEAR SHALL pulse oOverrun.
REQ-022 Without RENDER_ARB_CLEAR_EN, the CLEAR state and its counters SHALL NOT exist.

Structure
REQ-023 A shared package render_pkg SHALL hold the state encoding enum, the colour constants (COL_BLACK=3'b000, COL_WHITE=3'b111) and the default screen dimensions.
REQ-024 The sequencing FSM and the pixel mux SHALL stay in render_arbiter.
REQ-025 The CLEAR sweep SHALL be one sub-module, screen_sweep (start, x/y counters, done), instantiated only under RENDER_ARB_CLEAR_EN.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Normal frame: iReqEn=111, each requester asserts done 45 cycles after its start. Required: oReqStart pulses 0, 1, 2 in order; oFrameDone exactly once, 2 cycles after the last done (WAIT->FINISH cycle, then the FINISH output cycle); oPlot never high while oGrant=000.
- Skip: iReqEn=101. Required: oReqStart[1] never pulses; grant goes 001 to 100.
- Overrun and mux isolation: iFrameTick pulses while requester 0 is in WAIT, and requester 2 drives iReqPlot=1 with X=7, Y=9 in the same window. Required: oOverrun=1 next cycle; no restart; frame completes normally; the requester-2 pixel never appears on the bus.
- Stale done / latency: iReqDone[0] held at 1 before start. Required: grant persists for at least 2 WAIT cycles; a pixel X=100, Y=50, colour=111 appears on oX/oY/oColour exactly one cycle later.
- Reset mid-WAIT: iReset=1 during grant 010. Required: all outputs zero next cycle; the next frame starts at requester 0.
- CLEAR_EN build: after reset, 76800 plot cycles with colour 000; last pixel (319,239); then oBusy=0.
